// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state encoding and length-width helper for the sequence detector
package seq_det_pkg;
   typedef enum logic [1:0] {IDLE, FILL, ARMED} state_e;
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction
endpackage

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating match counter where a clear coincident with a match yields 1
module seq_match_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);
   logic [CNT_W-1:0] count_q, count_d;
   always_comb begin
      count_d = i_clr ? CNT_W'(i_inc) : (i_inc && count_q != '1) ? count_q + 1'b1 : count_q;
   end
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) count_q <= '0;
      else            count_q <= count_d;
   end
   assign o_count = count_q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable serial pattern detector with overlap mode and match counter
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 16,
   parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0001_0110),
   parameter int                 DEFAULT_LEN = 5,
   parameter bit                 DEFAULT_OVL = 1'b1
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_seq_in,
   input  logic                        i_valid,
   input  logic                        i_cfg_load,
   input  logic [MAX_LEN-1:0]          i_pattern,
   input  logic [len_w(MAX_LEN)-1:0]   i_pat_len,
   input  logic                        i_overlap,
   input  logic                        i_cnt_clr,
   output logic                        o_seq_detected,
   output logic                        o_armed,
   output logic [CNT_W-1:0]            o_match_count
);
   localparam int LW = len_w(MAX_LEN);
   localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
   state_e             state_q, state_d;
   logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, hist_sh, mask;
   logic [LW-1:0]      fill_q, fill_d, len_q, len_d, fill_inc;
   logic               ovl_q, ovl_d, det_q, det_d;
   always_comb begin
      hist_sh  = {hist_q[MAX_LEN-2:0], i_seq_in};
      fill_inc = (fill_q == MAX_L) ? fill_q : fill_q + 1'b1;
      for (int k = 0; k < MAX_LEN; k++) mask[k] = k < int'(len_q);
      // Compare the post-shift history so the completing bit counts this cycle
      det_d    = i_valid && !i_cfg_load && len_q != '0 && fill_inc >= len_q &&
                 ((hist_sh ^ pat_q) & mask) == '0;
      hist_d   = i_cfg_load ? '0 : i_valid ? hist_sh : hist_q;
      fill_d   = i_cfg_load ? '0 : !i_valid ? fill_q : (det_d && !ovl_q) ? '0 : fill_inc;
      pat_d    = i_cfg_load ? i_pattern : pat_q;
      len_d    = i_cfg_load ? ((i_pat_len > MAX_L) ? MAX_L : i_pat_len) : len_q;
      ovl_d    = i_cfg_load ? i_overlap : ovl_q;
      state_d  = (fill_d == '0) ? IDLE : (len_d != '0 && fill_d >= len_d) ? ARMED : FILL;
   end
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= DEFAULT_PAT;
         len_q   <= LW'(DEFAULT_LEN);
         ovl_q   <= DEFAULT_OVL;
         det_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         det_q   <= det_d;
      end
   end
   seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (i_cnt_clr),
      .i_inc     (det_d),
      .o_count   (o_match_count)
   );
   assign o_seq_detected = det_q;
   assign o_armed        = state_q == ARMED;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed and random stimulus checked against a queue-based reference model
module tb_seq_detector_param;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seq_in = 1'b0, valid = 1'b0, cfg_load = 1'b0, overlap = 1'b0, cnt_clr = 1'b0;
   logic [7:0]  pattern = '0;
   logic [3:0]  pat_len = '0;
   logic        det, armed, det2, armed2;
   logic [15:0] cnt;
   logic [1:0]  cnt2;
   int          n_chk = 0, n_pass = 0;
   string       phase = "reset";
   bit          q[$];
   logic [7:0]  m_pat;
   int          m_len, c16, c2;
   bit          m_ovl, exp_det;

   always #5 clk = ~clk;

   seq_detector_param dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_seq_in(seq_in), .i_valid(valid), .i_cfg_load(cfg_load),
      .i_pattern(pattern), .i_pat_len(pat_len), .i_overlap(overlap), .i_cnt_clr(cnt_clr),
      .o_seq_detected(det), .o_armed(armed), .o_match_count(cnt));

   seq_detector_param #(.CNT_W(2)) dut2 (
      .i_clk(clk), .i_reset_n(rst_n), .i_seq_in(seq_in), .i_valid(valid), .i_cfg_load(cfg_load),
      .i_pattern(pattern), .i_pat_len(pat_len), .i_overlap(overlap), .i_cnt_clr(cnt_clr),
      .o_seq_detected(det2), .o_armed(armed2), .o_match_count(cnt2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
   endtask

   function automatic bit model_hit();
      if (m_len == 0 || q.size() < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++)
         if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check_all();
      chk("det", {31'd0, det}, {31'd0, exp_det});
      chk("armed", {31'd0, armed}, {31'd0, (m_len > 0 && q.size() >= m_len)});
      chk("cnt", {16'd0, cnt}, c16);
      chk("cnt2", {30'd0, cnt2}, c2);
      chk("det2", {31'd0, det2}, {31'd0, exp_det});
   endtask

   task automatic model_reset();
      q.delete();
      m_pat = 8'b0001_0110; m_len = 5; m_ovl = 1'b1;
      c16 = 0; c2 = 0; exp_det = 1'b0;
   endtask

   task automatic step(input bit v, input bit b, input bit ld, input bit clr);
      valid = v; seq_in = b; cfg_load = ld; cnt_clr = clr;
      exp_det = 1'b0;
      if (ld) begin
         q.delete();
         m_pat = pattern; m_len = (pat_len > 8) ? 8 : int'(pat_len); m_ovl = overlap;
      end else if (v) begin
         q.push_back(b);
         if (q.size() > 8) void'(q.pop_front());
         if (model_hit()) begin
            exp_det = 1'b1;
            if (!m_ovl) q.delete();
         end
      end
      if (clr) begin
         c16 = exp_det ? 1 : 0; c2 = c16;
      end else if (exp_det) begin
         c16 = (c16 == 65535) ? c16 : c16 + 1;
         c2  = (c2 == 3) ? c2 : c2 + 1;
      end
      @(posedge clk); #1;
      check_all();
      valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; seq_in = $urandom_range(0, 1);
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
      pattern = p; pat_len = l; overlap = o;
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic stream(input logic [15:0] bits, input int n);
      logic [15:0] s;
      s = bits;
      for (int k = 0; k < n; k++) step(1'b1, s[n - 1 - k], 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all();
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk) rst_n = 1'b1;
      phase = "defaults";
      stream(16'b1011_0110, 8);
      chk("cnt_after_stream", {16'd0, cnt}, 32'd2);
      phase = "nonovl";
      load(8'b0001_0110, 4'd5, 1'b0);
      stream(16'b1011_0110, 8);
      chk("cnt_after_stream", {16'd0, cnt}, 32'd3);
      phase = "ones8";
      load(8'hFF, 4'd8, 1'b1);
      stream(16'h03FF, 10);
      phase = "ones_clamp";
      load(8'hFF, 4'd12, 1'b1);
      stream(16'h03FF, 10);
      phase = "gaps";
      load(8'b0001_0110, 4'd5, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(1'b1, (k == 1 || k == 4) ? 1'b0 : 1'b1, 1'b0, 1'b0);
         repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      phase = "clr_match";
      stream(16'b1011, 4);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("cnt_is_one", {16'd0, cnt}, 32'd1);
      phase = "sat2";
      stream(16'b1101_1011_0110, 12);
      stream(16'b110, 3);
      chk("cnt2_sat", {30'd0, cnt2}, 32'd3);
      phase = "len0";
      load(8'h00, 4'd0, 1'b1);
      stream(16'h0000, 9);
      phase = "midreset";
      load(8'b0001_0110, 4'd5, 1'b1);
      stream(16'b1011, 4);
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      phase = "load_with_valid";
      stream(16'b1011, 4);
      pattern = 8'b0001_0110; pat_len = 4'd5; overlap = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b0);
      phase = "random";
      for (int n = 0; n < 600; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 4) begin
            pattern = $urandom; pat_len = (r == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            overlap = $urandom_range(0, 1);
            step($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, $urandom_range(0, 1));
         end else if (r == 99) begin
            do_reset();
         end else begin
            step($urandom_range(0, 4) != 0, $urandom_range(0, 1), 1'b0, $urandom_range(0, 19) == 0);
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
